// File: rtl/preif_pc_gen_pkg.sv
// Shared CPU defines used by the pre-IF fetch-address stage.
//   ExceptinPipeType  : per-instruction exception flags carried down the pipe
//   redirect_class_t  : redirect priority class (higher value wins)
//   preif_buf_state_t : redirect-buffer FSM states
//   RESET_PC_DEFAULT  : fetch address after reset
package preif_pc_gen_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic Interrupt;
        logic WrongAddressinIF;      // AdEL on instruction fetch
        logic ReservedInstruction;
        logic Syscall;
        logic Break;
        logic Eret;
        logic Overflow;
        logic WrWrongAddressinMEM;
        logic RdWrongAddressinMEM;
    } ExceptinPipeType;

    typedef enum logic [1:0] {
        RC_NONE = 2'd0,
        RC_BR   = 2'd1,
        RC_ERET = 2'd2,
        RC_EXC  = 2'd3
    } redirect_class_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } preif_buf_state_t;

endpackage

// File: rtl/preif_redirect_buf.sv
// Pending-redirect buffer for the pre-IF stage. While fetch is stalled
// (PREIF_Wr=0) the highest-class redirect seen is held here until the
// next advance consumes it.
//   clk, rst (sync, active-low), PREIF_Wr : clock / reset / advance enable
//   live_valid/class/target               : already-prioritised live redirect
//   pend_class/target                     : buffered redirect
//   Redirect_Pending                      : high exactly in HOLD
module preif_redirect_buf
    import preif_pc_gen_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            PREIF_Wr,
    input  logic            live_valid,
    input  redirect_class_t live_class,
    input  logic [31:0]     live_target,
    output redirect_class_t pend_class,
    output logic [31:0]     pend_target,
    output logic            Redirect_Pending
);

    preif_buf_state_t state;

    // pend_class is RC_NONE in RUN, so the >= test also admits any first capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_RUN;
            pend_class  <= RC_NONE;
            pend_target <= '0;
        end else if (PREIF_Wr) begin
            state       <= ST_RUN;
            pend_class  <= RC_NONE;
            pend_target <= '0;
        end else if (live_valid && (live_class >= pend_class)) begin
            state       <= ST_HOLD;
            pend_class  <= live_class;
            pend_target <= live_target;
        end
    end

    assign Redirect_Pending = (state == ST_HOLD);

endmodule

// File: rtl/preif_pc_gen.sv
// Pre-IF fetch address generator: PC register plus next-PC selection.
//   clk, rst (sync, active-low)  : clock / reset
//   PREIF_Wr                     : advance enable (IF register write enable)
//   Exc_*, Eret_Valid/EPC, Br_*  : redirect requests, priority Exc > ERET > Br
//   PREIF_PC                     : registered fetch address
//   PREIF_ExceptType             : AdEL-on-fetch when PC is misaligned
//   Redirect_Pending             : a captured redirect awaits application
module preif_pc_gen
    import preif_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PREIF_Wr,
    input  logic            Exc_Valid,
    input  logic [31:0]     Exc_Vector,
    input  logic            Eret_Valid,
    input  logic [31:0]     EPC,
    input  logic            Br_Valid,
    input  logic [31:0]     Br_Target,
    output logic [31:0]     PREIF_PC,
    output ExceptinPipeType PREIF_ExceptType,
    output logic            Redirect_Pending
);

    logic [31:0]     pc_q;
    logic [31:0]     next_pc;
    logic            live_valid;
    redirect_class_t live_class;
    logic [31:0]     live_target;
    redirect_class_t pend_class;
    logic [31:0]     pend_target;

    always_comb begin
        live_valid  = 1'b1;
        live_class  = RC_NONE;
        live_target = '0;
        if (Exc_Valid) begin
            live_class  = RC_EXC;
            live_target = Exc_Vector;
        end else if (Eret_Valid) begin
            live_class  = RC_ERET;
            live_target = EPC;
        end else if (Br_Valid) begin
            live_class  = RC_BR;
            live_target = Br_Target;
        end else begin
            live_valid  = 1'b0;
        end
    end

    preif_redirect_buf u_redirect_buf (
        .clk              (clk),
        .rst              (rst),
        .PREIF_Wr         (PREIF_Wr),
        .live_valid       (live_valid),
        .live_class       (live_class),
        .live_target      (live_target),
        .pend_class       (pend_class),
        .pend_target      (pend_target),
        .Redirect_Pending (Redirect_Pending)
    );

    always_comb begin
        next_pc = pc_q + 32'd4;
        if (live_valid) begin
            next_pc = live_target;
        end else if (pend_class != RC_NONE) begin
            next_pc = pend_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (PREIF_Wr) begin
            pc_q <= next_pc;
        end
    end

    assign PREIF_PC = pc_q;

    // Misaligned targets pass through unmasked and are flagged here instead.
    always_comb begin
        PREIF_ExceptType                  = '0;
        PREIF_ExceptType.WrongAddressinIF = (pc_q[1:0] != 2'b00);
    end

endmodule

// File: tb/tb_preif_pc_gen.sv
module tb_preif_pc_gen;
    import preif_pc_gen_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            PREIF_Wr;
    logic            Exc_Valid;
    logic [31:0]     Exc_Vector;
    logic            Eret_Valid;
    logic [31:0]     EPC;
    logic            Br_Valid;
    logic [31:0]     Br_Target;
    logic [31:0]     PREIF_PC;
    ExceptinPipeType PREIF_ExceptType;
    logic            Redirect_Pending;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    ExceptinPipeType exp_adel;
    ExceptinPipeType exp_none;

    preif_pc_gen #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .PREIF_Wr         (PREIF_Wr),
        .Exc_Valid        (Exc_Valid),
        .Exc_Vector       (Exc_Vector),
        .Eret_Valid       (Eret_Valid),
        .EPC              (EPC),
        .Br_Valid         (Br_Valid),
        .Br_Target        (Br_Target),
        .PREIF_PC         (PREIF_PC),
        .PREIF_ExceptType (PREIF_ExceptType),
        .Redirect_Pending (Redirect_Pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_redirects();
        Exc_Valid  = 1'b0;
        Eret_Valid = 1'b0;
        Br_Valid   = 1'b0;
    endtask

    initial begin
        exp_none = '0;
        exp_adel = '0;
        exp_adel.WrongAddressinIF = 1'b1;

        rst = 1'b0; PREIF_Wr = 1'b1;
        Exc_Valid = 1'b1; Exc_Vector = 32'h1234_5678;
        Eret_Valid = 1'b0; EPC = 32'h0;
        Br_Valid = 1'b0; Br_Target = 32'h0;
        step(); step();
        chk("reset_pc", PREIF_PC, 32'hBFC0_0000);
        chk("reset_exc", 32'(PREIF_ExceptType), 32'(exp_none));
        chk("reset_pend", 32'(Redirect_Pending), 32'd0);

        // Sequential fetch
        idle_redirects(); rst = 1'b1; PREIF_Wr = 1'b1;
        step(); chk("seq1", PREIF_PC, 32'hBFC0_0004);
        step(); chk("seq2", PREIF_PC, 32'hBFC0_0008);
        step(); chk("seq3", PREIF_PC, 32'hBFC0_000C);

        // Exception beats branch
        Br_Valid = 1'b1; Br_Target = 32'h8000_1000;
        Exc_Valid = 1'b1; Exc_Vector = 32'hBFC0_0380;
        step(); chk("exc_over_br", PREIF_PC, 32'hBFC0_0380);

        // ERET beats branch
        Exc_Valid = 1'b0; Eret_Valid = 1'b1; EPC = 32'h8000_4000;
        step(); chk("eret_over_br", PREIF_PC, 32'h8000_4000);
        idle_redirects();

        // Stalled branch captured, held, then applied
        PREIF_Wr = 1'b0; Br_Valid = 1'b1; Br_Target = 32'h8000_2000;
        step();
        chk("cap_pend", 32'(Redirect_Pending), 32'd1);
        chk("cap_pc_held", PREIF_PC, 32'h8000_4000);
        idle_redirects();
        step(); step();
        chk("hold_pend", 32'(Redirect_Pending), 32'd1);
        chk("hold_pc", PREIF_PC, 32'h8000_4000);
        PREIF_Wr = 1'b1;
        step();
        chk("apply_pc", PREIF_PC, 32'h8000_2000);
        chk("apply_pend", 32'(Redirect_Pending), 32'd0);

        // Live redirect beats pending; pending cleared afterwards
        PREIF_Wr = 1'b0; Br_Valid = 1'b1; Br_Target = 32'h8000_5000;
        step();
        Br_Valid = 1'b0; PREIF_Wr = 1'b1; Eret_Valid = 1'b1; EPC = 32'h8000_6000;
        step(); chk("live_over_pend", PREIF_PC, 32'h8000_6000);
        idle_redirects();
        step(); chk("pend_cleared", PREIF_PC, 32'h8000_6004);

        // Pending exception not replaced by later lower-class branch
        PREIF_Wr = 1'b0; Exc_Valid = 1'b1; Exc_Vector = 32'hBFC0_0380;
        step();
        Exc_Valid = 1'b0; Br_Valid = 1'b1; Br_Target = 32'h8000_3000;
        step();
        idle_redirects(); PREIF_Wr = 1'b1;
        step(); chk("br_dropped", PREIF_PC, 32'hBFC0_0380);

        // Equal-class capture replaces pending
        PREIF_Wr = 1'b0; Br_Valid = 1'b1; Br_Target = 32'h8000_7000;
        step();
        Br_Target = 32'h8000_8000;
        step();
        idle_redirects(); PREIF_Wr = 1'b1;
        step(); chk("eq_replace", PREIF_PC, 32'h8000_8000);

        // Misaligned target flagged, not masked
        Br_Valid = 1'b1; Br_Target = 32'h8000_0002;
        step();
        chk("misal_pc", PREIF_PC, 32'h8000_0002);
        chk("misal_exc", 32'(PREIF_ExceptType), 32'(exp_adel));
        idle_redirects();
        step();
        chk("misal_seq_pc", PREIF_PC, 32'h8000_0006);
        chk("misal_seq_exc", 32'(PREIF_ExceptType), 32'(exp_adel));

        // PC+4 wraps
        Br_Valid = 1'b1; Br_Target = 32'hFFFF_FFFC;
        step();
        chk("aligned_exc", 32'(PREIF_ExceptType), 32'(exp_none));
        idle_redirects();
        step(); chk("wrap_pc", PREIF_PC, 32'h0000_0000);

        // Reset mid-HOLD discards pending
        PREIF_Wr = 1'b0; Br_Valid = 1'b1; Br_Target = 32'h8000_9000;
        step();
        chk("pre_rst_pend", 32'(Redirect_Pending), 32'd1);
        idle_redirects(); rst = 1'b0;
        step();
        chk("rst_hold_pc", PREIF_PC, 32'hBFC0_0000);
        chk("rst_hold_pend", 32'(Redirect_Pending), 32'd0);
        rst = 1'b1; PREIF_Wr = 1'b1;
        step(); chk("post_rst_seq", PREIF_PC, 32'hBFC0_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/preif_pc_gen.md
PREIF_PC_GEN -- requirements
Module: preif_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, the fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port PREIF_Wr  input  1  advance enable; the same signal that drives the IF register's write enable.
REQ-005 SHALL have port Exc_Valid  input  1  exception redirect request from the commit/CP0 path.
REQ-006 SHALL have port Exc_Vector  input  32  exception handler address.
REQ-007 SHALL have port Eret_Valid  input  1  ERET redirect request.
REQ-008 SHALL have port EPC  input  32  ERET return address.
REQ-009 SHALL have port Br_Valid  input  1  resolved branch/jump redirect request from ID/EX.
REQ-010 SHALL have port Br_Target  input  32  branch/jump target address.
REQ-011 SHALL have port PREIF_PC  output  32  current fetch address presented to the IF register.
REQ-012 SHALL have port PREIF_ExceptType  output  ExceptinPipeType  fetch-side exception flags presented to the IF register.
REQ-013 SHALL have port Redirect_Pending  output  1  high while a captured redirect awaits application.

Function
REQ-014 SHALL hold the fetch address in a 32-bit PC register; PREIF_PC SHALL be driven directly from this register with no combinational path from any input.
REQ-015 SHALL rank redirect priority as exception > ERET > branch > sequential (PC+4).
REQ-016 SHALL, when PREIF_Wr=1, load the PC with the highest-priority live redirect; if there is none, the pending redirect; if neither exists, PC+4. The load takes effect at the next edge (one-cycle latency).
REQ-017 SHALL, when PREIF_Wr=1, clear the pending buffer at the same edge.
REQ-018 SHALL, when PREIF_Wr=0, leave the PC unchanged.
REQ-019 SHALL, when PREIF_Wr=0 and any redirect is live, capture the highest-priority live redirect into the pending buffer (a target address plus a 2-bit class).
REQ-020 SHALL, during capture, let a live redirect replace the pending entry only when the live class is equal to or higher than the pending class; a lower-class live redirect SHALL be dropped.
REQ-021 SHALL implement a two-state FSM, RUN and HOLD:
- RUN to HOLD on capture (REQ-019).
- HOLD to RUN on any edge with PREIF_Wr=1.
- Redirect_Pending=1 exactly in HOLD.
REQ-022 SHALL compute PC+4 modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-023 SHALL set the AdEL-on-fetch field of PREIF_ExceptType when PREIF_PC[1:0]!=2'b00, and SHALL clear all other fields to zero.
REQ-024 SHALL accept a misaligned redirect target unmodified; the address is flagged by REQ-023, never masked.
REQ-025 SHALL ignore simultaneous Exc_Valid, Eret_Valid and Br_Valid except for the winner under REQ-015.

Reset
REQ-026 SHALL, on a rising edge with rst=0, set PC=RESET_PC, clear the pending buffer and class, and enter RUN, regardless of PREIF_Wr or any redirect input.
REQ-027 SHALL, while in reset, drive PREIF_PC=RESET_PC, PREIF_ExceptType all zero and Redirect_Pending=0.
REQ-028 SHALL discard a pending redirect when reset is asserted mid-HOLD; the first fetch after reset is RESET_PC.

Structure
REQ-029 SHALL take ExceptinPipeType, the redirect-class encoding, and the RESET_PC default value from the shared CPU defines package; none of these SHALL be defined locally.
REQ-030 SHALL factor the pending buffer and FSM into one sub-module, preif_redirect_buf; the PC register and next-PC mux stay in the top level.

Verification
REQ-031 Reset then PREIF_Wr=1 with no redirects for 3 edges -> PREIF_PC sequence BFC00000, BFC00004, BFC00008, BFC0000C.
REQ-032 Br_Valid=1 with Br_Target=0x80001000 and Exc_Valid=1 with Exc_Vector=0xBFC00380 in the same cycle, PREIF_Wr=1 -> next PREIF_PC=0xBFC00380.
REQ-033 Sequence:
- PREIF_Wr=0; Br_Valid=1 pulse with target 0x80002000 -> Redirect_Pending=1, PC held.
- Two more stall cycles -> state unchanged.
- Then PREIF_Wr=1 -> PREIF_PC=0x80002000 and Redirect_Pending=0.
REQ-034 Sequence:
- PREIF_Wr=0; Exc_Valid=1 pulse with vector 0xBFC00380 captured.
- Next cycle Br_Valid=1 with target 0x80003000.
- Then PREIF_Wr=1 -> PREIF_PC=0xBFC00380 (branch dropped).
REQ-035 Br_Target=0x80000002, PREIF_Wr=1 -> PREIF_PC=0x80000002 with AdEL-on-fetch field set.
REQ-036 Reset asserted while Redirect_Pending=1 -> PREIF_PC=0xBFC00000 and Redirect_Pending=0 after the edge.
